// File: rtl/queue_admission_ctrl.sv
// rtl/queue_admission_ctrl.sv - tail-drop admission controller with per-queue occupancy tracking
//
// Purpose:
//   Looks up each enqueue request's queue length limit in an external length
//   memory, compares it with a locally tracked occupancy, and emits an
//   accept/drop decision. Scheduler dequeue notifications decrement occupancy.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   enq_valid_i/enq_ready_o        enqueue request handshake (id, len)
//   deq_valid_i, deq_queue_id_i,
//   deq_len_i                      dequeue notification, no backpressure
//   lm_queue_id_o, lm_max_len_i    length-memory lookup (limit valid one cycle later)
//   dec_valid_o/dec_ready_i        decision handshake (accept, echoed id/len)
//   wb_*                           statistics read/clear port
//
// Optional feature:
//   QUEUE_ADMISSION_STATS_EN       saturating accept/drop counters on the Wishbone port

module queue_admission_ctrl #(
    parameter int QUEUE_ID_WIDTH         = 32,
    parameter int MAX_QUEUE_LENGTH_WIDTH = 24,
    parameter int PKT_LEN_WIDTH          = 16,
    parameter int WB_ADDR_WIDTH          = 22,
    parameter int WB_DATA_WIDTH          = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              enq_valid_i,
    output logic                              enq_ready_o,
    input  logic [QUEUE_ID_WIDTH-1:0]         enq_queue_id_i,
    input  logic [PKT_LEN_WIDTH-1:0]          enq_len_i,
    input  logic                              deq_valid_i,
    input  logic [QUEUE_ID_WIDTH-1:0]         deq_queue_id_i,
    input  logic [PKT_LEN_WIDTH-1:0]          deq_len_i,
    output logic [QUEUE_ID_WIDTH-1:0]         lm_queue_id_o,
    input  logic [MAX_QUEUE_LENGTH_WIDTH-1:0] lm_max_len_i,
    output logic                              dec_valid_o,
    input  logic                              dec_ready_i,
    output logic                              dec_accept_o,
    output logic [QUEUE_ID_WIDTH-1:0]         dec_queue_id_o,
    output logic [PKT_LEN_WIDTH-1:0]          dec_len_o,
    input  logic                              wb_cyc_i,
    input  logic                              wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]          wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]          wb_dat_i,
    output logic                              wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0]          wb_dat_o
);

    // One guard bit above the limit width so occupancy can never wrap.
    localparam int OCC_W = MAX_QUEUE_LENGTH_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_OUT
    } state_t;

    state_t state_q, state_d;

    logic [QUEUE_ID_WIDTH-1:0] id_q;
    logic [PKT_LEN_WIDTH-1:0]  len_q;
    logic [OCC_W-1:0]          occ_q [8];
    logic [OCC_W-1:0]          occ_d [8];
    logic [OCC_W:0]            inc_w [8];
    logic [OCC_W:0]            dq_w  [8];
    logic [OCC_W:0]            tot_w [8];

    logic [2:0]   sel;
    logic [OCC_W:0] len_ext;
    logic [OCC_W:0] deq_ext;
    logic [OCC_W:0] sum_w;
    logic [OCC_W:0] limit_ext;
    logic         accept_w;
    logic         do_check;
    logic         enq_commit;
    logic         wb_req;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        enq_ready_o = 1'b0;
        dec_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                enq_ready_o = 1'b1;
                if (enq_valid_i) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                dec_valid_o = 1'b1;
                if (dec_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Limit check: compares pre-update occupancy, widened so the sum of
    // occupancy and packet length cannot overflow.
    // ------------------------------------------------------------------
    assign sel        = id_q[2:0];
    assign len_ext    = {{(OCC_W + 1 - PKT_LEN_WIDTH){1'b0}}, len_q};
    assign deq_ext    = {{(OCC_W + 1 - PKT_LEN_WIDTH){1'b0}}, deq_len_i};
    assign sum_w      = {1'b0, occ_q[sel]} + len_ext;
    assign limit_ext  = {2'b00, lm_max_len_i};
    assign accept_w   = (sum_w <= limit_ext);
    assign do_check   = (state_q == ST_CHECK);
    assign enq_commit = do_check && accept_w;

    // Lookup id is simply the latched request id; it is stable from LOOKUP
    // through OUT because it only changes on the next IDLE handshake.
    assign lm_queue_id_o = id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q           <= '0;
            len_q          <= '0;
            dec_accept_o   <= 1'b0;
            dec_queue_id_o <= '0;
            dec_len_o      <= '0;
        end else begin
            if (state_q == ST_IDLE && enq_valid_i) begin
                id_q  <= enq_queue_id_i;
                len_q <= enq_len_i;
            end
            if (do_check) begin
                dec_accept_o   <= accept_w;
                dec_queue_id_o <= id_q;
                dec_len_o      <= len_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: add the accepted length first, then subtract the dequeued
    // length, clamping at zero. Handles a same-cycle accept and dequeue on
    // the same queue as a single combined update.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            inc_w[i] = '0;
            dq_w[i]  = '0;
            if (enq_commit && sel == 3'(i)) begin
                inc_w[i] = len_ext;
            end
            if (deq_valid_i && deq_queue_id_i[2:0] == 3'(i)) begin
                dq_w[i] = deq_ext;
            end
            tot_w[i] = {1'b0, occ_q[i]} + inc_w[i];
            occ_d[i] = (tot_w[i] > dq_w[i]) ? OCC_W'(tot_w[i] - dq_w[i]) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) begin
                occ_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                occ_q[i] <= occ_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Wishbone statistics port: single-cycle ack per request.
    // ------------------------------------------------------------------
    assign wb_req = wb_cyc_i && !wb_ack_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_ack_o <= 1'b0;
        end else begin
            wb_ack_o <= wb_req;
        end
    end

`ifdef QUEUE_ADMISSION_STATS_EN
    logic [31:0] acc_cnt_q;
    logic [31:0] drop_cnt_q;
    logic        unused_bits;

    assign unused_bits = ^{deq_queue_id_i[QUEUE_ID_WIDTH-1:3], wb_adr_i[WB_ADDR_WIDTH-1:1], wb_dat_i};

    // A write clear takes priority over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_cnt_q  <= '0;
            drop_cnt_q <= '0;
            wb_dat_o   <= '0;
        end else begin
            if (wb_req && wb_we_i && !wb_adr_i[0]) begin
                acc_cnt_q <= '0;
            end else if (do_check && accept_w && acc_cnt_q != 32'hFFFF_FFFF) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
            if (wb_req && wb_we_i && wb_adr_i[0]) begin
                drop_cnt_q <= '0;
            end else if (do_check && !accept_w && drop_cnt_q != 32'hFFFF_FFFF) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
            wb_dat_o <= wb_adr_i[0] ? WB_DATA_WIDTH'(drop_cnt_q) : WB_DATA_WIDTH'(acc_cnt_q);
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{deq_queue_id_i[QUEUE_ID_WIDTH-1:3], wb_we_i, wb_adr_i, wb_dat_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_dat_o <= '0;
        end else begin
            wb_dat_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_queue_admission_ctrl.sv
// tb/tb_queue_admission_ctrl.sv - self-checking bench for queue_admission_ctrl

module tb_queue_admission_ctrl;

    localparam int QW = 32;
    localparam int MW = 24;
    localparam int PW = 16;
    localparam int AW = 22;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          enq_valid_i;
    logic          enq_ready_o;
    logic [QW-1:0] enq_queue_id_i;
    logic [PW-1:0] enq_len_i;
    logic          deq_valid_i;
    logic [QW-1:0] deq_queue_id_i;
    logic [PW-1:0] deq_len_i;
    logic [QW-1:0] lm_queue_id_o;
    logic [MW-1:0] lm_max_len_i;
    logic          dec_valid_o;
    logic          dec_ready_i;
    logic          dec_accept_o;
    logic [QW-1:0] dec_queue_id_o;
    logic [PW-1:0] dec_len_o;
    logic          wb_cyc_i;
    logic          wb_we_i;
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_o;
    logic [DW-1:0] wb_dat_o;

    queue_admission_ctrl #(
        .QUEUE_ID_WIDTH(QW),
        .MAX_QUEUE_LENGTH_WIDTH(MW),
        .PKT_LEN_WIDTH(PW),
        .WB_ADDR_WIDTH(AW),
        .WB_DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .enq_valid_i(enq_valid_i),
        .enq_ready_o(enq_ready_o),
        .enq_queue_id_i(enq_queue_id_i),
        .enq_len_i(enq_len_i),
        .deq_valid_i(deq_valid_i),
        .deq_queue_id_i(deq_queue_id_i),
        .deq_len_i(deq_len_i),
        .lm_queue_id_o(lm_queue_id_o),
        .lm_max_len_i(lm_max_len_i),
        .dec_valid_o(dec_valid_o),
        .dec_ready_i(dec_ready_i),
        .dec_accept_o(dec_accept_o),
        .dec_queue_id_o(dec_queue_id_o),
        .dec_len_o(dec_len_o),
        .wb_cyc_i(wb_cyc_i),
        .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o),
        .wb_dat_o(wb_dat_o)
    );

    always #5 clk_i = ~clk_i;

    // Length memory model: registered read, one cycle after the lookup id.
    logic [MW-1:0] limits [8];
    always @(posedge clk_i) lm_max_len_i <= limits[lm_queue_id_o[2:0]];

    typedef struct {
        logic          acc;
        logic [QW-1:0] id;
        logic [PW-1:0] len;
    } exp_t;

    exp_t    sb[$];
    longint  m_occ [8];
    int      m_acc;
    int      m_drop;
    int      n_cmp;
    int      n_err;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_occ[i] = 0;
        m_acc  = 0;
        m_drop = 0;
        sb.delete();
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic do_enq(input logic [QW-1:0] id, input logic [PW-1:0] len, input bit with_deq,
                          input logic [QW-1:0] dqid, input logic [PW-1:0] dqlen, input int hold);
        exp_t e;
        exp_t snap;
        int   k;
        longint t;
        @(negedge clk_i);
        n_cmp++;
        if (enq_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL enq_ready_idle: got %b expected 1", enq_ready_o);
        end
        if (hold > 0) dec_ready_i = 1'b0;
        e.acc = ((m_occ[id[2:0]] + longint'(len)) <= longint'(limits[id[2:0]]));
        e.id  = id;
        e.len = len;
        sb.push_back(e);
        if (e.acc) begin
            m_occ[id[2:0]] += longint'(len);
            m_acc++;
        end else begin
            m_drop++;
        end
        if (with_deq) begin
            t = m_occ[dqid[2:0]] - longint'(dqlen);
            m_occ[dqid[2:0]] = (t < 0) ? 0 : t;
        end
        enq_valid_i    = 1'b1;
        enq_queue_id_i = id;
        enq_len_i      = len;
        @(negedge clk_i);
        enq_valid_i = 1'b0;
        n_cmp++;
        if (lm_queue_id_o !== id) begin
            n_err++;
            $display("FAIL lm_queue_id: got %0h expected %0h", lm_queue_id_o, id);
        end
        @(negedge clk_i);
        if (with_deq) begin
            deq_valid_i    = 1'b1;
            deq_queue_id_i = dqid;
            deq_len_i      = dqlen;
        end
        @(negedge clk_i);
        deq_valid_i = 1'b0;
        k = 0;
        while (dec_valid_o !== 1'b1 && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        n_cmp++;
        if (k != 0) begin
            n_err++;
            $display("FAIL dec_latency: got %0d extra cycles expected 0", k);
        end
        if (dec_valid_o !== 1'b1) begin
            void'(sb.pop_front());
            dec_ready_i = 1'b1;
            return;
        end
        if (hold > 0) begin
            snap.acc = dec_accept_o;
            snap.id  = dec_queue_id_o;
            snap.len = dec_len_o;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk_i);
                n_cmp++;
                if (dec_valid_o !== 1'b1 || dec_accept_o !== snap.acc || dec_queue_id_o !== snap.id ||
                    dec_len_o !== snap.len || enq_ready_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%b a=%b id=%0h len=%0h rdy=%b expected v=1 a=%b id=%0h len=%0h rdy=0",
                             dec_valid_o, dec_accept_o, dec_queue_id_o, dec_len_o, enq_ready_o,
                             snap.acc, snap.id, snap.len);
                end
            end
            dec_ready_i = 1'b1;
        end
        e = sb.pop_front();
        n_cmp++;
        if (dec_accept_o !== e.acc) begin
            n_err++;
            $display("FAIL dec_accept q%0h len %0d: got %b expected %b", e.id, e.len, dec_accept_o, e.acc);
        end
        n_cmp++;
        if (dec_queue_id_o !== e.id || dec_len_o !== e.len) begin
            n_err++;
            $display("FAIL dec_echo: got id=%0h len=%0h expected id=%0h len=%0h",
                     dec_queue_id_o, dec_len_o, e.id, e.len);
        end
        @(negedge clk_i);
        n_cmp++;
        if (dec_valid_o !== 1'b0 || enq_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL return_idle: got v=%b rdy=%b expected v=0 rdy=1", dec_valid_o, enq_ready_o);
        end
    endtask

    task automatic enq(input logic [QW-1:0] id, input logic [PW-1:0] len);
        do_enq(id, len, 1'b0, '0, '0, 0);
    endtask

    task automatic do_deq(input logic [QW-1:0] id, input logic [PW-1:0] len);
        longint t;
        @(negedge clk_i);
        deq_valid_i    = 1'b1;
        deq_queue_id_i = id;
        deq_len_i      = len;
        t = m_occ[id[2:0]] - longint'(len);
        m_occ[id[2:0]] = (t < 0) ? 0 : t;
        @(negedge clk_i);
        deq_valid_i = 1'b0;
    endtask

    task automatic wb_access(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] exp_dat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        n_cmp++;
        if (wb_ack_o !== 1'b1) begin
            n_err++;
            $display("FAIL wb_ack_pulse: got %b expected 1", wb_ack_o);
        end
        if (!we) begin
            n_cmp++;
            if (wb_dat_o !== exp_dat) begin
                n_err++;
                $display("FAIL wb_read adr %0d: got %0d expected %0d", adr, wb_dat_o, exp_dat);
            end
        end
        @(negedge clk_i);
        n_cmp++;
        if (wb_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL wb_ack_drop: got %b expected 0", wb_ack_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (enq_ready_o !== 1'b1 || dec_valid_o !== 1'b0 || dec_accept_o !== 1'b0 ||
            dec_queue_id_o !== '0 || dec_len_o !== '0 || lm_queue_id_o !== '0 ||
            wb_ack_o !== 1'b0 || wb_dat_o !== '0) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b v=%b a=%b id=%0h len=%0h lm=%0h ack=%b dat=%0h expected 1,0,0,0,0,0,0,0",
                     enq_ready_o, dec_valid_o, dec_accept_o, dec_queue_id_o, dec_len_o,
                     lm_queue_id_o, wb_ack_o, wb_dat_o);
        end
        apply_reset();
    endtask

    task automatic test_tail_drop();
        limits[0] = 24'd128;
        enq(32'h0, 16'd100);
        enq(32'h0, 16'd28);
        enq(32'h0, 16'd1);
    endtask

    task automatic test_deq_saturation();
        do_deq(32'h0, 16'd200);
        enq(32'h0, 16'd128);
    endtask

    task automatic test_backpressure();
        limits[5] = 24'd50;
        do_enq(32'h0000_0F05, 16'd20, 1'b0, '0, '0, 5);
    endtask

    task automatic test_same_cycle();
        limits[1] = 24'd100;
        enq(32'hABC0_0001, 16'd32);
        do_enq(32'hABC0_0001, 16'd64, 1'b1, 32'h0000_0001, 16'd16, 0);
        limits[1] = 24'd80;
        enq(32'hABC0_0001, 16'd1);
        limits[1] = 24'd81;
        enq(32'hABC0_0001, 16'd1);
    endtask

    task automatic test_reset_mid();
        int seen;
        limits[6] = 24'd1000;
        enq(32'h6, 16'd300);
        @(negedge clk_i);
        enq_valid_i    = 1'b1;
        enq_queue_id_i = 32'h6;
        enq_len_i      = 16'd10;
        @(negedge clk_i);
        enq_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (enq_ready_o !== 1'b1 || dec_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got rdy=%b v=%b expected rdy=1 v=0", enq_ready_o, dec_valid_o);
        end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (dec_valid_o !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_mid_no_decision: got %0d valid cycles expected 0", seen);
        end
        limits[6] = 24'd10;
        enq(32'h6, 16'd10);
        limits[0] = 24'd128;
        enq(32'h0, 16'd128);
    endtask

    task automatic test_stats();
        logic [DW-1:0] exp_acc;
        logic [DW-1:0] exp_drop;
        @(negedge clk_i);
        apply_reset();
        limits[2] = 24'd10;
        limits[3] = 24'd0;
        enq(32'h2, 16'd5);
        enq(32'h2, 16'd5);
        enq(32'h2, 16'd1);
        enq(32'h2, 16'd0);
        enq(32'h3, 16'd1);
`ifdef QUEUE_ADMISSION_STATS_EN
        exp_acc  = DW'(m_acc);
        exp_drop = DW'(m_drop);
`else
        exp_acc  = '0;
        exp_drop = '0;
`endif
        wb_access(1'b0, 22'd0, exp_acc);
        wb_access(1'b0, 22'd1, exp_drop);
        wb_access(1'b1, 22'd1, '0);
        wb_access(1'b0, 22'd1, '0);
        wb_access(1'b0, 22'd0, exp_acc);
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst_ni         = 1'b1;
        enq_valid_i    = 1'b0;
        enq_queue_id_i = '0;
        enq_len_i      = '0;
        deq_valid_i    = 1'b0;
        deq_queue_id_i = '0;
        deq_len_i      = '0;
        dec_ready_i    = 1'b1;
        wb_cyc_i       = 1'b0;
        wb_we_i        = 1'b0;
        wb_adr_i       = '0;
        wb_dat_i       = '0;
        for (int i = 0; i < 8; i++) limits[i] = '0;
        model_reset();
        #1;
        test_reset();
        test_tail_drop();
        test_deq_saturation();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
